// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests the icache, predicts the next PC and feeds ID.
// Build option: define BTB_EN to include the direct-mapped BTB; otherwise the next PC is always pc+4.
module if_fetch_unit #(
    parameter int unsigned BTB_IDX_W = 6,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,

    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_inst_i,

    output logic [31:0] pre_raddr_o,
    input  logic        pre_taken_i,

    input  logic        btb_we_i,
    input  logic [31:0] btb_waddr_i,
    input  logic [31:0] btb_target_i,

    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,

    input  logic        stall_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_pre_taken_o,
    output logic [31:0] id_pre_target_o
);

    localparam logic [0:0] FETCH   = 1'b0;
    localparam logic [0:0] WAIT_ID = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] npc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        slot_free;

    logic [31:0] skid_pc;
    logic [31:0] skid_inst;
    logic        skid_taken;
    logic [31:0] skid_target;

`ifdef BTB_EN
    localparam int unsigned ENTRIES = 1 << BTB_IDX_W;
    localparam int unsigned TAG_W   = 30 - BTB_IDX_W;

    logic [ENTRIES-1:0]   btb_valid;
    logic [TAG_W-1:0]     btb_tag [ENTRIES];
    logic [31:0]          btb_tgt [ENTRIES];
    logic [BTB_IDX_W-1:0] ridx;
    logic [BTB_IDX_W-1:0] widx;
    logic                 hit;
    logic                 unused_waddr_lsb;

    assign ridx             = pc[BTB_IDX_W+1:2];
    assign widx             = btb_waddr_i[BTB_IDX_W+1:2];
    assign unused_waddr_lsb = ^btb_waddr_i[1:0];

    always_comb begin
        hit         = btb_valid[ridx] && (btb_tag[ridx] == pc[31:BTB_IDX_W+2]);
        pred_taken  = hit & pre_taken_i;
        pred_target = btb_tgt[ridx];
    end

    // Only the valid bits need reset; tag/target contents are qualified by them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (rdy && btb_we_i) begin
            btb_valid[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && btb_we_i) begin
            btb_tag[widx] <= btb_waddr_i[31:BTB_IDX_W+2];
            btb_tgt[widx] <= btb_target_i;
        end
    end
`else
    logic unused_btb;

    assign unused_btb = ^{btb_we_i, btb_waddr_i, btb_target_i, pre_taken_i};

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = '0;
    end
`endif

    assign pc_plus4    = pc + 32'd4;
    assign npc         = pred_taken ? pred_target : pc_plus4;
    assign slot_free   = !id_valid_o || !stall_i;

    assign mem_req_o   = (state == FETCH);
    assign mem_addr_o  = pc;
    assign pre_raddr_o = pc;

    // The skid is full exactly when the FSM sits in WAIT_ID, so no separate skid valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc              <= RESET_PC;
            state           <= FETCH;
            id_valid_o      <= 1'b0;
            id_pc_o         <= '0;
            id_inst_o       <= '0;
            id_pre_taken_o  <= 1'b0;
            id_pre_target_o <= '0;
            skid_pc         <= '0;
            skid_inst       <= '0;
            skid_taken      <= 1'b0;
            skid_target     <= '0;
        end else if (rdy) begin
            if (redirect_i) begin
                pc         <= {redirect_pc_i[31:2], 2'b00};
                state      <= FETCH;
                id_valid_o <= 1'b0;
            end else if (state == FETCH) begin
                if (mem_ack_i) begin
                    pc <= npc;
                    if (slot_free) begin
                        id_valid_o      <= 1'b1;
                        id_pc_o         <= pc;
                        id_inst_o       <= mem_inst_i;
                        id_pre_taken_o  <= pred_taken;
                        id_pre_target_o <= npc;
                    end else begin
                        skid_pc     <= pc;
                        skid_inst   <= mem_inst_i;
                        skid_taken  <= pred_taken;
                        skid_target <= npc;
                        state       <= WAIT_ID;
                    end
                end else if (!stall_i) begin
                    id_valid_o <= 1'b0;
                end
            end else if (!stall_i) begin
                id_valid_o      <= 1'b1;
                id_pc_o         <= skid_pc;
                id_inst_o       <= skid_inst;
                id_pre_taken_o  <= skid_taken;
                id_pre_target_o <= skid_target;
                state           <= FETCH;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_if_fetch_unit;

`ifdef BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_inst_i;
    logic [31:0] pre_raddr_o;
    logic        pre_taken_i;
    logic        btb_we_i;
    logic [31:0] btb_waddr_i;
    logic [31:0] btb_target_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_pre_taken_o;
    logic [31:0] id_pre_target_o;

    if_fetch_unit #(.BTB_IDX_W(6), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_inst_i(mem_inst_i),
        .pre_raddr_o(pre_raddr_o), .pre_taken_i(pre_taken_i),
        .btb_we_i(btb_we_i), .btb_waddr_i(btb_waddr_i), .btb_target_i(btb_target_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .stall_i(stall_i),
        .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
        .id_pre_taken_o(id_pre_taken_o), .id_pre_target_o(id_pre_target_o)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; mem_ack_i = 1'b0; mem_inst_i = '0; pre_taken_i = 1'b0;
        btb_we_i = 1'b0; btb_waddr_i = '0; btb_target_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        #2 rst = 1'b0;
    endtask

    typedef struct {
        logic        ack;
        logic        stall;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[8];

    // Reference model: ID slot plus skid are one FIFO of at most two fetched packets.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [31:0] tgt;
    } pkt_t;

    pkt_t        mq[$];
    logic [31:0] m_pc;
    bit          m_bv [64];
    logic [31:0] m_ba [64];
    logic [31:0] m_bt [64];

    task automatic model_reset();
        mq.delete();
        m_pc = 32'h0;
        for (int i = 0; i < 64; i++) m_bv[i] = 1'b0;
    endtask

    task automatic model_step();
        int          idx;
        bit          hit;
        bit          taken;
        logic [31:0] nxt;
        bit          req;
        pkt_t        p;
        if (!rdy) return;
        idx   = int'(m_pc[7:2]);
        hit   = BTB_ON && m_bv[idx] && (m_ba[idx][31:2] == m_pc[31:2]);
        taken = hit && pre_taken_i;
        nxt   = taken ? m_bt[idx] : m_pc + 32'd4;
        if (redirect_i) begin
            mq.delete();
            m_pc = {redirect_pc_i[31:2], 2'b00};
        end else begin
            req = (mq.size() < 2);
            if (mq.size() > 0 && !stall_i) void'(mq.pop_front());
            if (req && mem_ack_i) begin
                p.pc = m_pc; p.inst = mem_inst_i; p.taken = taken; p.tgt = nxt;
                mq.push_back(p);
                m_pc = nxt;
            end
        end
        if (btb_we_i) begin
            idx = int'(btb_waddr_i[7:2]);
            m_bv[idx] = 1'b1;
            m_ba[idx] = btb_waddr_i;
            m_bt[idx] = btb_target_i;
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b1, 32'h04};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 32'h08};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h08};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0C};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0C};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0C};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h10};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h10};

        idle();
        do_reset();
        chk("reset_req", 32'(mem_req_o), 32'd1);
        chk("reset_addr", mem_addr_o, 32'h0);
        chk("reset_valid", 32'(id_valid_o), 32'd0);
        chk("reset_id_pc", id_pc_o, 32'h0);
        chk("reset_id_inst", id_inst_o, 32'h0);
        chk("reset_id_target", id_pre_target_o, 32'h0);

        // Sequential fetch, stall into skid, release
        for (int i = 0; i < 8; i++) begin
            mem_ack_i  = tbl[i].ack;
            stall_i    = tbl[i].stall;
            mem_inst_i = 32'hA000_0000 + 32'(i);
            tick();
            chk($sformatf("tbl%0d_valid", i), 32'(id_valid_o), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_req", i), 32'(mem_req_o), 32'(tbl[i].exp_req));
            chk($sformatf("tbl%0d_addr", i), mem_addr_o, tbl[i].exp_addr);
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_pc", i), id_pc_o, tbl[i].exp_pc);
                chk($sformatf("tbl%0d_target", i), id_pre_target_o, tbl[i].exp_pc + 32'd4);
            end
        end

        // Reset in the middle of fetching
        idle(); mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        rst = 1'b1;
        #2;
        chk("midrst_req", 32'(mem_req_o), 32'd1);
        chk("midrst_addr", mem_addr_o, 32'h0);
        chk("midrst_valid", 32'(id_valid_o), 32'd0);
        rst = 1'b0;
        tick();
        chk("midrst_addr_after", mem_addr_o, 32'h0);
        chk("midrst_valid_after", 32'(id_valid_o), 32'd0);

        // PC wrap
        idle(); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        chk("wrap_addr", mem_addr_o, 32'hFFFF_FFFC);
        idle(); mem_ack_i = 1'b1;
        tick();
        chk("wrap_id_pc", id_pc_o, 32'hFFFF_FFFC);
        chk("wrap_target", id_pre_target_o, 32'h0);
        chk("wrap_next", mem_addr_o, 32'h0);

        // Redirect with full skid and simultaneous ack
        idle(); redirect_i = 1'b1; redirect_pc_i = 32'h100;
        tick();
        idle(); mem_ack_i = 1'b1;
        tick();
        stall_i = 1'b1;
        tick();
        chk("skid_req", 32'(mem_req_o), 32'd0);
        chk("skid_id_pc", id_pc_o, 32'h100);
        redirect_i = 1'b1; redirect_pc_i = 32'h203; mem_ack_i = 1'b1; stall_i = 1'b1;
        tick();
        chk("redir_valid", 32'(id_valid_o), 32'd0);
        chk("redir_addr", mem_addr_o, 32'h200);
        chk("redir_req", 32'(mem_req_o), 32'd1);
        idle();
        tick();
        chk("redir_skid_gone", 32'(id_valid_o), 32'd0);
        mem_ack_i = 1'b1;
        tick();
        chk("redir_fetch_pc", id_pc_o, 32'h200);

        // rdy low freezes everything, including BTB writes
        idle(); rdy = 1'b0; mem_ack_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300;
        btb_we_i = 1'b1; btb_waddr_i = 32'h204; btb_target_i = 32'h3C0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("frz%0d_valid", i), 32'(id_valid_o), 32'd1);
            chk($sformatf("frz%0d_pc", i), id_pc_o, 32'h200);
            chk($sformatf("frz%0d_addr", i), mem_addr_o, 32'h204);
        end
        idle(); mem_ack_i = 1'b1; pre_taken_i = 1'b1;
        tick();
        chk("frz_btb_pc", id_pc_o, 32'h204);
        chk("frz_btb_taken", 32'(id_pre_taken_o), 32'd0);
        chk("frz_btb_next", mem_addr_o, 32'h208);

        // BTB hit/taken, write during redirect
        idle(); redirect_i = 1'b1; redirect_pc_i = 32'h10;
        btb_we_i = 1'b1; btb_waddr_i = 32'h10; btb_target_i = 32'h80;
        tick();
        idle(); mem_ack_i = 1'b1; pre_taken_i = 1'b1;
        tick();
        chk("btb_taken", 32'(id_pre_taken_o), BTB_ON ? 32'd1 : 32'd0);
        chk("btb_target", id_pre_target_o, BTB_ON ? 32'h80 : 32'h14);
        chk("btb_next", mem_addr_o, BTB_ON ? 32'h80 : 32'h14);
        idle(); redirect_i = 1'b1; redirect_pc_i = 32'h10;
        tick();
        idle(); mem_ack_i = 1'b1; pre_taken_i = 1'b0;
        tick();
        chk("btb_nt_taken", 32'(id_pre_taken_o), 32'd0);
        chk("btb_nt_next", mem_addr_o, 32'h14);

        // Same-cycle write/read of one index uses the old entry
        idle(); mem_ack_i = 1'b1; pre_taken_i = 1'b1;
        btb_we_i = 1'b1; btb_waddr_i = 32'h14; btb_target_i = 32'h40;
        tick();
        chk("wr_rd_taken", 32'(id_pre_taken_o), 32'd0);
        chk("wr_rd_next", mem_addr_o, 32'h18);
        idle(); redirect_i = 1'b1; redirect_pc_i = 32'h14;
        tick();
        idle(); mem_ack_i = 1'b1; pre_taken_i = 1'b1;
        tick();
        chk("revisit_taken", 32'(id_pre_taken_o), BTB_ON ? 32'd1 : 32'd0);
        chk("revisit_next", mem_addr_o, BTB_ON ? 32'h40 : 32'h18);
        idle(); redirect_i = 1'b1; redirect_pc_i = 32'h114;
        tick();
        idle(); mem_ack_i = 1'b1; pre_taken_i = 1'b1;
        tick();
        chk("tag_miss_taken", 32'(id_pre_taken_o), 32'd0);
        chk("tag_miss_next", mem_addr_o, 32'h118);

        // Randomized traffic against the reference model
        idle();
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rdy           = ($urandom_range(0, 9) != 0);
            mem_ack_i     = ($urandom_range(0, 9) < 6);
            mem_inst_i    = $urandom;
            pre_taken_i   = $urandom_range(0, 1) == 1;
            stall_i       = ($urandom_range(0, 9) < 3);
            redirect_i    = ($urandom_range(0, 19) == 0);
            redirect_pc_i = $urandom_range(0, 511);
            btb_we_i      = ($urandom_range(0, 6) == 0);
            btb_waddr_i   = ($urandom_range(0, 1) == 1) ? m_pc : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            btb_target_i  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            model_step();
            tick();
            chk("rnd_req", 32'(mem_req_o), (mq.size() < 2) ? 32'd1 : 32'd0);
            chk("rnd_addr", mem_addr_o, m_pc);
            chk("rnd_raddr", pre_raddr_o, m_pc);
            chk("rnd_valid", 32'(id_valid_o), (mq.size() > 0) ? 32'd1 : 32'd0);
            if (mq.size() > 0) begin
                chk("rnd_id_pc", id_pc_o, mq[0].pc);
                chk("rnd_id_inst", id_inst_o, mq[0].inst);
                chk("rnd_id_taken", 32'(id_pre_taken_o), 32'(mq[0].taken));
                chk("rnd_id_target", id_pre_target_o, mq[0].tgt);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
